// File: rtl/alu_param_seq_if.sv
// Operand/opcode request and result/flag response bundle for alu_param_seq.
interface alu_param_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       cs;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic             out_valid;
    logic             busy;

    modport master (
        output in_valid, a, b, cs,
        input  in_ready, result, flags, out_valid, busy
    );

    modport slave (
        input  in_valid, a, b, cs,
        output in_ready, result, flags, out_valid, busy
    );
endinterface

// File: rtl/alu_param_seq.sv
// WIDTH-bit datapath ALU: single-cycle logic/arithmetic plus iterative shifts and
// shift-add multiply, with a valid/ready operand handshake and V/Z/N/C flags.
module alu_param_seq #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    alu_param_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    K_MAX = CW'(WIDTH);
    localparam logic [WIDTH-1:0] B_MAX = WIDTH'(WIDTH);
    localparam logic signed [WIDTH:0] S_MAX = $signed({2'b00, {(WIDTH-1){1'b1}}});
    localparam logic signed [WIDTH:0] S_MIN = $signed({2'b11, {(WIDTH-1){1'b0}}});

    localparam logic [4:0] OP_ADD   = 5'b00001;
    localparam logic [4:0] OP_AND   = 5'b00010;
    localparam logic [4:0] OP_OR    = 5'b00011;
    localparam logic [4:0] OP_XOR   = 5'b00100;
    localparam logic [4:0] OP_NOTA  = 5'b00101;
    localparam logic [4:0] OP_SHL1  = 5'b00110;
    localparam logic [4:0] OP_PASSA = 5'b00111;
    localparam logic [4:0] OP_SUB   = 5'b01000;
    localparam logic [4:0] OP_SHLN  = 5'b01001;
    localparam logic [4:0] OP_SHRN  = 5'b01010;
    localparam logic [4:0] OP_MUL   = 5'b01011;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic             busy_q;
    logic             vld_p1;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    kq;

    logic [4:0]       opc_p1;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] acc_p1;
    logic [WIDTH-1:0] hi_p1;
    logic             c_p1;

    function automatic logic [3:0] mk_flags(input logic v, input logic [WIDTH-1:0] r,
                                            input logic c);
        return {v, (r == '0), r[WIDTH-1], c};
    endfunction

    function automatic logic ovf(input logic signed [WIDTH:0] s);
        return (s > S_MAX) || (s < S_MIN);
    endfunction

    logic [WIDTH:0]        u_sum;
    logic [WIDTH:0]        u_dif;
    logic signed [WIDTH:0] s_sum;
    logic signed [WIDTH:0] s_dif;
    logic [WIDTH-1:0]      sc_res;
    logic [3:0]            sc_flags;
    logic                  sc_hold;
    logic                  is_iter;
    logic [CW-1:0]         k_in;

    // Accept stage: single-cycle results and iteration count for the multi-cycle ops
    always_comb begin
        u_sum    = {1'b0, bus.a} + {1'b0, bus.b};
        u_dif    = {1'b0, bus.a} - {1'b0, bus.b};
        s_sum    = $signed({bus.a[WIDTH-1], bus.a}) + $signed({bus.b[WIDTH-1], bus.b});
        s_dif    = $signed({bus.a[WIDTH-1], bus.a}) - $signed({bus.b[WIDTH-1], bus.b});
        sc_res   = result_q;
        sc_flags = flags_q;
        sc_hold  = 1'b0;
        is_iter  = 1'b0;
        k_in     = (bus.b >= B_MAX) ? K_MAX : bus.b[CW-1:0];
        case (bus.cs)
            OP_ADD: begin
                sc_res   = u_sum[WIDTH-1:0];
                sc_flags = mk_flags(ovf(s_sum), u_sum[WIDTH-1:0], u_sum[WIDTH]);
            end
            OP_AND: begin
                sc_res   = bus.a & bus.b;
                sc_flags = mk_flags(1'b0, bus.a & bus.b, bus.a != bus.b);
            end
            OP_OR: begin
                sc_res   = bus.a | bus.b;
                sc_flags = mk_flags(1'b0, bus.a | bus.b, bus.a != bus.b);
            end
            OP_XOR: begin
                sc_res   = bus.a ^ bus.b;
                sc_flags = mk_flags(1'b0, bus.a ^ bus.b, bus.a != bus.b);
            end
            OP_NOTA: begin
                sc_res   = ~bus.a;
                sc_flags = mk_flags(1'b0, ~bus.a, 1'b0);
            end
            OP_SHL1: begin
                sc_res   = {bus.a[WIDTH-2:0], 1'b0};
                sc_flags = mk_flags(1'b0, {bus.a[WIDTH-2:0], 1'b0}, bus.a[WIDTH-1]);
            end
            OP_PASSA: begin
                sc_res   = bus.a;
                sc_flags = mk_flags(flags_q[3], bus.a, flags_q[0]);
            end
            OP_SUB: begin
                sc_res   = u_dif[WIDTH-1:0];
                sc_flags = mk_flags(ovf(s_dif), u_dif[WIDTH-1:0], u_dif[WIDTH]);
            end
            // A zero-length shift completes like a single-cycle op and returns a unchanged
            OP_SHLN, OP_SHRN: begin
                sc_res   = bus.a;
                sc_flags = mk_flags(1'b0, bus.a, 1'b0);
                is_iter  = (k_in != '0);
            end
            OP_MUL: begin
                is_iter = 1'b1;
                k_in    = K_MAX;
            end
            default: sc_hold = 1'b1;
        endcase
    end

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] step_hi;
    logic             step_c;
    logic [3:0]       step_flags;
    logic [CW-1:0]    cnt_nxt;

    // Iteration stage: one shift bit or one multiplier bit per BUSY cycle
    always_comb begin
        cnt_nxt  = cnt + CW'(1);
        mul_sum  = {1'b0, hi_p1} + (acc_p1[0] ? {1'b0, a_p1} : '0);
        step_acc = acc_p1;
        step_hi  = hi_p1;
        step_c   = c_p1;
        case (opc_p1)
            OP_SHLN: begin
                step_acc = {acc_p1[WIDTH-2:0], 1'b0};
                step_c   = acc_p1[WIDTH-1];
            end
            OP_SHRN: begin
                step_acc = {1'b0, acc_p1[WIDTH-1:1]};
                step_c   = acc_p1[0];
            end
            // {hi, acc} is the running product; the multiplier drains out of acc's LSB
            OP_MUL: begin
                step_hi  = mul_sum[WIDTH:1];
                step_acc = {mul_sum[0], acc_p1[WIDTH-1:1]};
                step_c   = 1'b0;
            end
            default: ;
        endcase
        if (opc_p1 == OP_MUL) begin
            step_flags = mk_flags(step_hi != '0, step_acc, step_hi != '0);
        end else begin
            step_flags = mk_flags(1'b0, step_acc, step_c);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            vld_p1   <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            cnt      <= '0;
            kq       <= '0;
        end else begin
            vld_p1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (is_iter) begin
                            state  <= BUSY;
                            busy_q <= 1'b1;
                            cnt    <= '0;
                            kq     <= k_in;
                        end else begin
                            vld_p1 <= 1'b1;
                            if (!sc_hold) begin
                                result_q <= sc_res;
                                flags_q  <= sc_flags;
                            end
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt_nxt;
                    if (cnt_nxt == kq) begin
                        state    <= IDLE;
                        busy_q   <= 1'b0;
                        vld_p1   <= 1'b1;
                        result_q <= step_acc;
                        flags_q  <= step_flags;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Working registers need no reset: they are always loaded at accept before use
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.in_valid && is_iter) begin
            opc_p1 <= bus.cs;
            a_p1   <= bus.a;
            acc_p1 <= (bus.cs == OP_MUL) ? bus.b : bus.a;
            hi_p1  <= '0;
            c_p1   <= 1'b0;
        end else if (state == BUSY) begin
            acc_p1 <= step_acc;
            hi_p1  <= step_hi;
            c_p1   <= step_c;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = busy_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign bus.out_valid = vld_p1;
endmodule
